// File: rtl/tc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tc_pkg : shared types and constants for the tensor-core sequencer  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package tc_pkg;

  typedef logic [15:0] fp16_t;
  typedef logic [31:0] fp32_t;

  typedef fp16_t [0:3][0:3] fp16_tile_t;
  typedef fp32_t [0:3][0:3] fp32_tile_t;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    LOAD_C = 3'd2,
    SETTLE = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  localparam int TILE_ELEMS = 16;

endpackage
`default_nettype wire

// File: rtl/tc_tile_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tc_tile_sequencer_if : operand input and result output streams     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface tc_tile_sequencer_if;
  import tc_pkg::*;

  logic  in_valid;
  logic  in_ready;
  fp32_t in_data;
  logic  acc_mode;
  logic  out_valid;
  logic  out_ready;
  fp32_t out_data;
  logic  tile_done;

  // master: the environment feeding operands and draining results
  modport master (
    output in_valid, in_data, acc_mode, out_ready,
    input  in_ready, out_valid, out_data, tile_done
  );

  // slave: the sequencer
  modport slave (
    input  in_valid, in_data, acc_mode, out_ready,
    output in_ready, out_valid, out_data, tile_done
  );

endinterface
`default_nettype wire

// File: rtl/tc_tile_reg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tc_tile_reg : 16-entry row-major tile register, indexed write or   |
// | full-tile parallel load (load has priority).          Rev 1.0      |
// +--------------------------------------------------------------------+
module tc_tile_reg
  import tc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [3:0]               idx,
  input  logic [W-1:0]             wdata,
  input  logic                     load,
  input  logic [0:3][0:3][W-1:0]   load_data,
  output logic [0:3][0:3][W-1:0]   q
);

  logic [0:3][0:3][W-1:0] tile_q;
  logic [0:3][0:3][W-1:0] tile_d;

  always_comb begin
    tile_d = tile_q;
    if (load) begin
      tile_d = load_data;
    end else if (we) begin
      tile_d[idx[3:2]][idx[1:0]] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_q <= '0;
    end else begin
      tile_q <= tile_d;
    end
  end

  assign q = tile_q;

endmodule
`default_nettype wire

// File: rtl/tc_tile_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tc_tile_sequencer : stages A/B/C tiles for the 4x4x4 core, waits   |
// | SETTLE cycles, captures D and streams it out.         Rev 1.0      |
// +--------------------------------------------------------------------+
module tc_tile_sequencer
  import tc_pkg::fp16_tile_t, tc_pkg::fp32_tile_t, tc_pkg::state_t, tc_pkg::TILE_ELEMS;
#(
  parameter int SETTLE = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  tc_tile_sequencer_if.slave        io,
  output fp16_tile_t                core_a,
  output fp16_tile_t                core_b,
  output fp32_tile_t                core_c,
  input  fp32_tile_t                core_d
);

  localparam logic [3:0] LAST_IDX   = 4'(TILE_ELEMS - 1);
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [3:0] idx_q,   idx_d;
  logic [3:0] cnt_q,   cnt_d;
  logic       acc_q,   acc_d;

  logic       we_a, we_b, we_c, load_c, cap_d;
  logic       last_idx;
  fp32_tile_t dcap;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.tile_done = 1'b0;
    we_a         = 1'b0;
    we_b         = 1'b0;
    we_c         = 1'b0;
    load_c       = 1'b0;
    cap_d        = 1'b0;
    last_idx     = (idx_q == LAST_IDX);

    case (state_q)
      tc_pkg::LOAD_A: begin
        io.in_ready = 1'b1;
        if (io.in_valid) begin
          we_a  = 1'b1;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd0) begin
            acc_d = io.acc_mode;
          end
          if (last_idx) begin
            state_d = tc_pkg::LOAD_B;
          end
        end
      end
      tc_pkg::LOAD_B: begin
        io.in_ready = 1'b1;
        if (io.in_valid) begin
          we_b  = 1'b1;
          idx_d = idx_q + 4'd1;
          // Accumulate: previous D becomes C in the same cycle B completes
          if (last_idx) begin
            if (acc_q) begin
              load_c  = 1'b1;
              state_d = tc_pkg::SETTLE;
            end else begin
              state_d = tc_pkg::LOAD_C;
            end
          end
        end
      end
      tc_pkg::LOAD_C: begin
        io.in_ready = 1'b1;
        if (io.in_valid) begin
          we_c  = 1'b1;
          idx_d = idx_q + 4'd1;
          if (last_idx) begin
            state_d = tc_pkg::SETTLE;
          end
        end
      end
      tc_pkg::SETTLE: begin
        if (cnt_q == SETTLE_CNT) begin
          cap_d   = 1'b1;
          cnt_d   = 4'd0;
          state_d = tc_pkg::DRAIN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      tc_pkg::DRAIN: begin
        io.out_valid = 1'b1;
        if (io.out_ready) begin
          idx_d = idx_q + 4'd1;
          if (last_idx) begin
            io.tile_done = 1'b1;
            state_d      = tc_pkg::LOAD_A;
          end
        end
      end
      default: begin
        state_d = tc_pkg::LOAD_A;
        idx_d   = 4'd0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= tc_pkg::LOAD_A;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign io.out_data = dcap[idx_q[3:2]][idx_q[1:0]];

  tc_tile_reg #(.W(16)) u_tile_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we_a),
    .idx       (idx_q),
    .wdata     (io.in_data[15:0]),
    .load      (1'b0),
    .load_data ('0),
    .q         (core_a)
  );

  tc_tile_reg #(.W(16)) u_tile_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we_b),
    .idx       (idx_q),
    .wdata     (io.in_data[15:0]),
    .load      (1'b0),
    .load_data ('0),
    .q         (core_b)
  );

  tc_tile_reg #(.W(32)) u_tile_c (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we_c),
    .idx       (idx_q),
    .wdata     (io.in_data),
    .load      (load_c),
    .load_data (dcap),
    .q         (core_c)
  );

  // D capture: only ever parallel-loaded from the core, survives across tiles
  tc_tile_reg #(.W(32)) u_tile_d (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (1'b0),
    .idx       (idx_q),
    .wdata     ('0),
    .load      (cap_d),
    .load_data (core_d),
    .q         (dcap)
  );

endmodule
`default_nettype wire

// File: tb/tb_tc_tile_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for tc_tile_sequencer: a real-arithmetic tensor core model feeds core_d,
// and an array-based reference predicts staged tiles and the result stream.
module tb_tc_tile_sequencer;
  import tc_pkg::fp16_tile_t;
  import tc_pkg::fp32_tile_t;

  localparam int SETTLE_CYC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tc_tile_sequencer_if io();
  fp16_tile_t core_a, core_b;
  fp32_tile_t core_c, core_d;

  tc_tile_sequencer #(.SETTLE(SETTLE_CYC)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io     (io),
    .core_a (core_a),
    .core_b (core_b),
    .core_c (core_c),
    .core_d (core_d)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] ma[16], mb[16];
  logic [31:0] mc[16], ceff[16], mdcap[16], exp_d[16];

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else        repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real r;
    if (h[14:10] == 5'd0) return 0.0;
    r = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
    return h[15] ? -r : r;
  endfunction

  function automatic real f2r(input logic [31:0] f);
    real r;
    if (f[30:23] == 8'd0) return 0.0;
    r = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(int'(f[30:23]) - 127);
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic s;
    int   e;
    real  a;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction

  // Behavioural tensor core: D = A*B + C
  function automatic fp32_tile_t core_fn(input fp16_tile_t a, input fp16_tile_t b, input fp32_tile_t c);
    fp32_tile_t d;
    real s;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0.0;
        for (int k = 0; k < 4; k++) s = s + h2r(a[i][k]) * h2r(b[k][j]);
        s = s + f2r(c[i][j]);
        d[i][j] = r2f(s);
      end
    end
    return d;
  endfunction

  always_comb core_d = core_fn(core_a, core_b, core_c);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(7))
      0: return 16'h0000;
      1: return 16'h3C00;
      2: return 16'hBC00;
      3: return 16'h4000;
      4: return 16'h3800;
      5: return 16'hC000;
      6: return 16'h4200;
      default: return 16'hB800;
    endcase
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(7))
      0: return 32'h00000000;
      1: return 32'h3F800000;
      2: return 32'hBF800000;
      3: return 32'h40000000;
      4: return 32'h3F000000;
      5: return 32'h40400000;
      6: return 32'hC0400000;
      default: return 32'h41200000;
    endcase
  endfunction

  task automatic check_staging(input string ph);
    for (int e = 0; e < 16; e++) begin
      check($sformatf("%s_a[%0d]", ph, e), {16'h0, core_a[e[3:2]][e[1:0]]}, {16'h0, ma[e]});
      check($sformatf("%s_b[%0d]", ph, e), {16'h0, core_b[e[3:2]][e[1:0]]}, {16'h0, mb[e]});
      check($sformatf("%s_c[%0d]", ph, e), core_c[e[3:2]][e[1:0]], ceff[e]);
    end
  endtask

  task automatic check_zero(input string ph);
    for (int e = 0; e < 16; e++) begin
      check($sformatf("%s_a[%0d]", ph, e), {16'h0, core_a[e[3:2]][e[1:0]]}, 32'h0);
      check($sformatf("%s_b[%0d]", ph, e), {16'h0, core_b[e[3:2]][e[1:0]]}, 32'h0);
      check($sformatf("%s_c[%0d]", ph, e), core_c[e[3:2]][e[1:0]], 32'h0);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic acc, input bit gap);
    int t = 0;
    if (gap) begin
      io.in_valid = 1'b0;
      io.in_data  = $urandom;
      @(negedge clk);
    end
    io.in_valid = 1'b1;
    io.in_data  = d;
    io.acc_mode = acc;
    #1;
    while (!io.in_ready && t < 64) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 64) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input bit garbage, input bit stall5);
    int k = 0;
    int t = 0;
    bit stalled = 1'b0;
    while (k < 16 && t < 1000) begin
      if (garbage) io.in_data = $urandom;
      if (stall5 && k == 7 && !stalled) begin
        stalled = 1'b1;
        io.out_ready = 1'b0;
        repeat (5) begin
          #1;
          check("stall_data", io.out_data, exp_d[7]);
          check("stall_valid", {31'h0, io.out_valid}, 32'd1);
          check("stall_done", {31'h0, io.tile_done}, 32'd0);
          @(negedge clk);
          t++;
        end
      end
      io.out_ready = ($urandom_range(3) != 0);
      #1;
      check("drain_in_ready", {31'h0, io.in_ready}, 32'd0);
      if (io.out_valid && io.out_ready) begin
        check($sformatf("out_data[%0d]", k), io.out_data, exp_d[k]);
        check($sformatf("tile_done[%0d]", k), {31'h0, io.tile_done}, {31'h0, k == 15});
        k++;
      end else begin
        check($sformatf("drain_valid[%0d]", k), {31'h0, io.out_valid}, 32'd1);
        check($sformatf("held_data[%0d]", k), io.out_data, exp_d[k]);
      end
      @(negedge clk);
      t++;
    end
    io.out_ready = 1'b0;
    io.in_valid  = 1'b0;
    if (k < 16) check("drain_timeout", k, 32'd16);
    #1;
    check("post_out_valid", {31'h0, io.out_valid}, 32'd0);
    check("post_in_ready", {31'h0, io.in_ready}, 32'd1);
  endtask

  task automatic run_tile(input bit acc, input bit gap, input bit garbage, input bit stall5);
    int  lat;
    real s;
    for (int e = 0; e < 16; e++) ceff[e] = acc ? mdcap[e] : mc[e];
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0.0;
        for (int k = 0; k < 4; k++) s = s + h2r(ma[i*4+k]) * h2r(mb[k*4+j]);
        s = s + f2r(ceff[i*4+j]);
        exp_d[i*4+j] = r2f(s);
      end
    end
    for (int e = 0; e < 16; e++)
      send_word({16'($urandom), ma[e]}, (e == 0) ? acc : 1'($urandom), gap);
    for (int e = 0; e < 16; e++)
      send_word({16'($urandom), mb[e]}, 1'($urandom), gap);
    if (acc) begin
      #1;
      check("acc_skips_c", {31'h0, io.in_ready}, 32'd0);
    end else begin
      for (int e = 0; e < 16; e++) send_word(mc[e], 1'($urandom), gap);
    end
    io.in_valid = garbage;
    io.in_data  = $urandom;
    lat = 0;
    #1;
    while (!io.out_valid && lat < 64) begin
      @(negedge clk);
      #1;
      lat++;
      if (garbage) io.in_data = $urandom;
    end
    check("latency", lat, SETTLE_CYC + 1);
    check_staging("hold_settle");
    drain(garbage, stall5);
    check_staging("hold_drain");
    for (int e = 0; e < 16; e++) mdcap[e] = exp_d[e];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.acc_mode  = 1'b0;
    io.out_ready = 1'b0;
    for (int e = 0; e < 16; e++) mdcap[e] = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", {31'h0, io.in_ready}, 32'd1);
    check("rst_out_valid", {31'h0, io.out_valid}, 32'd0);
    check("rst_tile_done", {31'h0, io.tile_done}, 32'd0);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // identity A, ones B, C = 1.0
    for (int e = 0; e < 16; e++) begin
      ma[e] = (e[3:2] == e[1:0]) ? 16'h3C00 : 16'h0000;
      mb[e] = 16'h3C00;
      mc[e] = 32'h3F800000;
    end
    run_tile(1'b0, 1'b0, 1'b0, 1'b0);

    // all ones, C = 0, then chained accumulate
    for (int e = 0; e < 16; e++) begin
      ma[e] = 16'h3C00;
      mb[e] = 16'h3C00;
      mc[e] = 32'h0;
    end
    run_tile(1'b0, 1'b0, 1'b0, 1'b0);
    run_tile(1'b1, 1'b0, 1'b0, 1'b0);

    // gapped input and a long output stall
    run_tile(1'b0, 1'b1, 1'b0, 1'b1);

    // garbage on the input bus while settling and draining
    for (int e = 0; e < 16; e++) begin
      ma[e] = rnd16();
      mb[e] = rnd16();
      mc[e] = rnd32();
    end
    run_tile(1'b0, 1'b0, 1'b1, 1'b0);

    // reset after 20 input words
    for (int e = 0; e < 16; e++) send_word({16'h0, rnd16()}, 1'b0, 1'b0);
    for (int e = 0; e < 4; e++)  send_word({16'h0, rnd16()}, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    io.in_valid = 1'b0;
    #1;
    check("midrst_in_ready", {31'h0, io.in_ready}, 32'd1);
    check("midrst_out_valid", {31'h0, io.out_valid}, 32'd0);
    check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 16; e++) mdcap[e] = 32'h0;
    @(negedge clk);

    // accumulate straight after reset sees C = 0
    for (int e = 0; e < 16; e++) begin
      ma[e] = rnd16();
      mb[e] = rnd16();
      mc[e] = rnd32();
    end
    run_tile(1'b1, 1'b0, 1'b0, 1'b0);

    repeat (8) begin
      for (int e = 0; e < 16; e++) begin
        ma[e] = rnd16();
        mb[e] = rnd16();
        mc[e] = rnd32();
      end
      run_tile(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
